// File: rtl/huffman_dec_if.sv
// rtl/huffman_dec_if.sv - Packed-word input and decoded-codeword output bundle for huffman_dec
interface huffman_dec_if #(
   parameter int W = 8,
   parameter int C = 4
);
   logic [W-1:0] d_in;
   logic         en_in;
   logic         rdy_in;
   logic [W-1:0] d_out;
   logic [C-1:0] w_out;
   logic [3:0]   sym_out;
   logic         en_out;

   modport master (
      output d_in, en_in,
      input  rdy_in, d_out, w_out, sym_out, en_out
   );

   modport slave (
      input  d_in, en_in,
      output rdy_in, d_out, w_out, sym_out, en_out
   );
endinterface

// File: rtl/huffman_dec.sv
// rtl/huffman_dec.sv - Prefix-code decoder for the packed Huffman word stream (one codeword per cycle)
// Defining HUFF_DEC_STATS_EN adds a saturating decoded-symbol counter on sym_cnt.
module huffman_dec #(
   parameter int W   = 8,
   parameter int C   = 4,
   parameter int BUF = 16
) (
   input  logic         clk,
   input  logic         rst,
   huffman_dec_if.slave io,
   input  logic         flush,
   output logic         err_out,
   output logic [15:0]  sym_cnt
);
   localparam int CW = $clog2(BUF + 1);

   logic [BUF-1:0] buf_q, buf_d, shifted;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_after, ones, wlen, cons;
   logic [W-1:0]   head, code;
   logic           complete, illegal, accept, lsb, strobe;

   assign io.rdy_in = (cnt_q <= CW'(BUF - W));
   assign accept    = io.en_in && io.rdy_in && !flush;
   assign head      = buf_q[BUF-1 -: W];

   // Bits past cnt are always zero, so the ones count never runs into stale data.
   always_comb begin
      logic stop;
      ones = '0;
      stop = 1'b0;
      lsb  = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (!stop) begin
            if (head[W-1-i]) ones = ones + CW'(1);
            else             stop = 1'b1;
         end
      end
      for (int i = 0; i < W - 1; i++) begin
         if (ones == CW'(i)) lsb = head[W-2-i];
      end
   end

   assign wlen      = ones + CW'(2);
   assign complete  = (ones <= CW'(W - 2)) && (cnt_q >= wlen);
   assign illegal   = (cnt_q >= CW'(W)) && (ones == CW'(W));
   assign cons      = complete ? wlen : (illegal ? CW'(W) : '0);
   assign shifted   = buf_q << cons;
   assign cnt_after = cnt_q - cons;
   assign code      = head & ~({W{1'b1}} >> wlen);
   assign strobe    = complete && !flush;

   // New word lands directly behind whatever survives this cycle's consume.
   always_comb begin
      buf_d = shifted;
      cnt_d = cnt_after;
      if (flush) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         buf_d = shifted | ({io.d_in, {(BUF-W){1'b0}}} >> cnt_after);
         cnt_d = cnt_after + CW'(W);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q      <= '0;
         cnt_q      <= '0;
         io.d_out   <= '0;
         io.w_out   <= '0;
         io.sym_out <= '0;
         io.en_out  <= 1'b0;
         err_out    <= 1'b0;
      end else begin
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         io.en_out <= strobe;
         if (strobe) begin
            io.d_out   <= code;
            io.w_out   <= wlen[C-1:0];
            io.sym_out <= {ones[2:0], lsb};
         end
         if (illegal && !flush) err_out <= 1'b1;
      end
   end

`ifdef HUFF_DEC_STATS_EN
   logic [15:0] sym_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sym_cnt_q <= '0;
      end else if (strobe && sym_cnt_q != 16'hFFFF) begin
         sym_cnt_q <= sym_cnt_q + 16'd1;
      end
   end

   assign sym_cnt = sym_cnt_q;
`else
   assign sym_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_huffman_dec.sv
// tb/tb_huffman_dec.sv - Self-checking bench for huffman_dec: vector table, corner sequences, random streams
`timescale 1ns/1ps
module tb_huffman_dec;
   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        err_out;
   logic [15:0] sym_cnt;

   huffman_dec_if #(.W(8), .C(4)) bus ();

   huffman_dec #(.W(8), .C(4), .BUF(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .io      (bus),
      .flush   (flush),
      .err_out (err_out),
      .sym_cnt (sym_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] w;
      logic [3:0] s;
   } strobe_t;

   typedef struct {
      logic [7:0] word;
      int         n;
      logic [7:0] d;
      logic [3:0] w;
      logic [3:0] s;
   } vec_t;

   strobe_t got_q[$];
   strobe_t exp_q[$];
   bit      bits_q[$];
   bit      model_err;
   int      n_strobe = 0;
   int      base = 0;
   int      total = 0;
   int      bad = 0;

   always @(negedge clk) begin
      if (bus.en_out) begin
         got_q.push_back({bus.d_out, bus.w_out, bus.sym_out});
         n_strobe++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.en_in = 1'b0;
      bus.d_in = '0;
      flush = 1'b0;
      step(2);
      rst = 1'b1;
      base = n_strobe;
      model_err = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
   endtask

   task automatic clear_all();
      got_q.delete();
      exp_q.delete();
      bits_q.delete();
   endtask

   task automatic send_word(input logic [7:0] w);
      int t;
      t = 0;
      bus.d_in = w;
      bus.en_in = 1'b1;
      @(negedge clk);
      while (!bus.rdy_in && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         total++;
         bad++;
         $display("FAIL send_word timeout: rdy_in stayed 0 for %0d cycles, expected 1", t);
      end
      @(posedge clk);
      #1;
      bus.en_in = 1'b0;
   endtask

   task automatic send_m(input logic [7:0] w);
      for (int j = 7; j >= 0; j--) bits_q.push_back(w[j]);
      send_word(w);
   endtask

   // Stream-level reference: walk the bit sequence, splitting prefix codes by rule.
   task automatic model_run();
      int p;
      int k;
      strobe_t s;
      p = 0;
      while (1) begin
         k = 0;
         while (p + k < bits_q.size() && bits_q[p+k] && k < W) k++;
         if (k == W) begin
            model_err = 1'b1;
            p += W;
         end else if (k > W - 2 || p + k + 2 > bits_q.size()) begin
            break;
         end else begin
            s.d = '0;
            for (int j = 0; j < k + 2; j++) s.d[7-j] = bits_q[p+j];
            s.w = 4'(k + 2);
            s.s = 4'(2 * k + int'(bits_q[p+k+1]));
            exp_q.push_back(s);
            p += k + 2;
         end
      end
   endtask

   task automatic compare_queues(input string name);
      int n;
      check({name, " count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s[%0d]", name, i), {16'h0, got_q[i]}, {16'h0, exp_q[i]});
   endtask

   task automatic add_code(input int k, input int l);
      strobe_t s;
      s.d = '0;
      for (int j = 0; j < k; j++) begin
         s.d[7-j] = 1'b1;
         bits_q.push_back(1'b1);
      end
      bits_q.push_back(1'b0);
      bits_q.push_back(l[0]);
      s.d[6-k] = l[0];
      s.w = 4'(k + 2);
      s.s = 4'(2 * k + l);
      exp_q.push_back(s);
   endtask

   function automatic logic [15:0] exp_sym_cnt();
`ifdef HUFF_DEC_STATS_EN
      return 16'(n_strobe - base);
`else
      return 16'h0000;
`endif
   endfunction

   vec_t tbl[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int acc;
      bit stalled;
      int bad_burst;
      logic [7:0] w;
      logic [7:0] words[3];

      tbl[0] = '{8'h11, 4, 8'h00, 4'd2, 4'd0};
      tbl[1] = '{8'h44, 4, 8'h40, 4'd2, 4'd1};
      tbl[2] = '{8'h80, 3, 8'h80, 4'd3, 4'd2};
      tbl[3] = '{8'hB0, 3, 8'hA0, 4'd3, 4'd3};
      tbl[4] = '{8'hD0, 3, 8'hD0, 4'd4, 4'd5};
      tbl[5] = '{8'hE0, 2, 8'hE0, 4'd5, 4'd6};
      tbl[6] = '{8'hF8, 1, 8'hF8, 4'd7, 4'd10};
      tbl[7] = '{8'hFC, 1, 8'hFC, 4'd8, 4'd12};
      tbl[8] = '{8'hFD, 1, 8'hFD, 4'd8, 4'd13};
      tbl[9] = '{8'h00, 4, 8'h00, 4'd2, 4'd0};

      do_reset();
      @(negedge clk);
      check("reset d_out", bus.d_out, 0);
      check("reset w_out", bus.w_out, 0);
      check("reset sym_out", bus.sym_out, 0);
      check("reset en_out", bus.en_out, 0);
      check("reset err_out", err_out, 0);
      check("reset sym_cnt", sym_cnt, 0);
      check("reset rdy_in", bus.rdy_in, 1);
      step(1);

      for (int i = 0; i < 10; i++) begin
         do_flush();
         got_q.delete();
         send_word(tbl[i].word);
         step(12);
         check($sformatf("vec%0d count", i), got_q.size(), tbl[i].n);
         if (got_q.size() > 0)
            check($sformatf("vec%0d first", i), {16'h0, got_q[0]},
                  {16'h0, tbl[i].d, tbl[i].w, tbl[i].s});
      end

      do_flush();
      clear_all();
      send_m(8'h11);
      send_m(8'h11);
      step(16);
      model_run();
      compare_queues("pairs00_01");

      // After the three-word run the buffer must be empty, so 0x40 decodes cleanly behind it.
      do_flush();
      clear_all();
      send_m(8'h96);
      send_m(8'h59);
      send_m(8'h65);
      send_m(8'h40);
      step(20);
      model_run();
      compare_queues("codes100_101");

      do_flush();
      got_q.delete();
      acc = 0;
      stalled = 1'b0;
      bus.d_in = 8'h00;
      bus.en_in = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.rdy_in) acc++;
         else stalled = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.en_in = 1'b0;
      step(30);
      check("burst strobes", got_q.size(), 4 * acc);
      check("burst rdy dropped", stalled, 1);
      bad_burst = 0;
      foreach (got_q[i]) if (got_q[i] != 16'h0020) bad_burst++;
      check("burst codes", bad_burst, 0);

      do_flush();
      got_q.delete();
      send_word(8'hE0);
      do_flush();
      step(6);
      check("flush drops pending", got_q.size(), 0);
      send_word(8'h40);
      step(10);
      check("after flush count", got_q.size(), 4);
      if (got_q.size() > 0) check("after flush first", {16'h0, got_q[0]}, {16'h0, 8'h40, 4'd2, 4'd1});
      check("sym_cnt", sym_cnt, exp_sym_cnt());

      for (int r = 0; r < 3; r++) begin
         do_flush();
         clear_all();
         for (int n = 0; n < 30; n++) add_code($urandom_range(0, 6), $urandom_range(0, 1));
         while (bits_q.size() % 8 != 0) begin
            if (bits_q.size() % 2 == 1) add_code(1, 0);
            else                        add_code(0, 0);
         end
         for (int i = 0; i < bits_q.size() / 8; i++) begin
            for (int j = 0; j < 8; j++) w[7-j] = bits_q[8*i+j];
            send_word(w);
            step($urandom_range(0, 2));
         end
         step(40);
         compare_queues($sformatf("rand%0d", r));
      end
      check("sym_cnt random", sym_cnt, exp_sym_cnt());

      do_flush();
      clear_all();
      model_err = 1'b0;
      send_m(8'hFC);
      send_m(8'hFF);
      step(10);
      model_run();
      compare_queues("illegal");
      check("err_out set", err_out, model_err);
      do_flush();
      step(3);
      check("err_out sticky", err_out, 1);
      check("sym_cnt end", sym_cnt, exp_sym_cnt());

      words[0] = 8'h80;
      send_word(words[0]);
      do_reset();
      @(negedge clk);
      check("rereset err_out", err_out, 0);
      check("rereset sym_cnt", sym_cnt, 0);
      step(1);
      got_q.delete();
      send_word(8'h44);
      step(10);
      check("post reset count", got_q.size(), 4);
      if (got_q.size() > 0) check("post reset first", {16'h0, got_q[0]}, {16'h0, 8'h40, 4'd2, 4'd1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
